// File: rtl/instruction_encoder_if.sv
// Request and issue handshake bundle for the instruction encoder.
interface instruction_encoder_if;
  logic        i_Valid;
  logic        o_Ready;
  logic [1:0]  i_Mode;
  logic [3:0]  i_Opcode;
  logic [2:0]  i_AddrReg1;
  logic [2:0]  i_AddrReg2;
  logic [7:0]  i_Imm;
  logic [15:0] o_Instr;
  logic        o_InstrValid;
  logic        i_InstrReady;

  // Encoder side: accepts requests, issues instruction words.
  modport slave (
    input  i_Valid, i_Mode, i_Opcode, i_AddrReg1, i_AddrReg2, i_Imm, i_InstrReady,
    output o_Ready, o_Instr, o_InstrValid
  );

  // Source/consumer side: drives requests, takes instruction words.
  modport master (
    output i_Valid, i_Mode, i_Opcode, i_AddrReg1, i_AddrReg2, i_Imm, i_InstrReady,
    input  o_Ready, o_Instr, o_InstrValid
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs operation requests into 16-bit instruction words and issues them in
// order through a small FIFO. Illegal modes are accepted, dropped and flagged.
module instruction_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                i_CLK,
  input  logic                i_RSTn,
  instruction_encoder_if.slave bus,
  output logic                o_Illegal,
  input  logic                i_ClrIllegal,
  output logic [ADDR_W:0]     o_Count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              illegal;
  logic [15:0]       word;
  logic              ready;
  logic              valid;
  logic              accept;
  logic              push;
  logic              pop;

  // Encode the current request fields into an instruction word.
  always_comb begin
    word = '0;
    if (bus.i_Mode[0] == 1'b0)
      word = {2'b00, bus.i_Opcode, bus.i_AddrReg1, bus.i_AddrReg2, 4'b0000};
    else
      word = {2'b01, bus.i_AddrReg1, bus.i_Imm, 3'b000};
  end

  // Handshake qualifiers derived from registered occupancy only (no bypass).
  always_comb begin
    ready  = (count < FULL);
    valid  = (count != '0);
    accept = bus.i_Valid && ready;
    push   = accept && !bus.i_Mode[1];
    pop    = valid && bus.i_InstrReady;
  end

  // FIFO storage; not reset, contents are unobservable while count is zero.
  always_ff @(posedge i_CLK) begin
    if (push)
      mem[wr_ptr] <= word;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky illegal flag; a new illegal accept takes priority over clear.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn)
      illegal <= 1'b0;
    else if (accept && bus.i_Mode[1])
      illegal <= 1'b1;
    else if (i_ClrIllegal)
      illegal <= 1'b0;
  end

  // Output drive; head word is masked to zero while the FIFO is empty.
  always_comb begin
    bus.o_Ready      = ready;
    bus.o_InstrValid = valid;
    bus.o_Instr      = valid ? mem[rd_ptr] : 16'h0000;
    o_Illegal        = illegal;
    o_Count          = count;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: vector table, directed
// multi-cycle sequences and randomized traffic against a queue model.
module tb_instruction_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       illegal;
  logic       clr;
  logic [2:0] count;

  always #5 clk = ~clk;

  instruction_encoder_if bus ();

  instruction_encoder #(.DEPTH(4), .ADDR_W(2)) dut (
    .i_CLK        (clk),
    .i_RSTn       (rst_n),
    .bus          (bus),
    .o_Illegal    (illegal),
    .i_ClrIllegal (clr),
    .o_Count      (count)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] q[$];
  logic        m_ill = 1'b0;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  op;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [7:0]  imm;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Word layout from field positions, computed arithmetically.
  function automatic logic [15:0] enc(input logic [1:0] mode, input logic [3:0] op,
                                      input logic [2:0] r1, input logic [2:0] r2,
                                      input logic [7:0] imm);
    int unsigned w;
    if (mode[0] == 1'b0) w = op * 1024 + r1 * 128 + r2 * 16;
    else                 w = 16384 + r1 * 2048 + imm * 8;
    return 16'(w);
  endfunction

  task automatic model_check(input string tag);
    check({tag, "_ready"}, 16'(bus.o_Ready), 16'(q.size() < 4));
    check({tag, "_valid"}, 16'(bus.o_InstrValid), 16'(q.size() != 0));
    check({tag, "_instr"}, bus.o_Instr, (q.size() != 0) ? q[0] : 16'h0000);
    check({tag, "_count"}, 16'(count), 16'(q.size()));
    check({tag, "_illegal"}, 16'(illegal), 16'(m_ill));
  endtask

  task automatic drive(input logic v, input logic [1:0] mode, input logic [3:0] op,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [7:0] imm,
                       input logic rdy, input logic c);
    bus.i_Valid      = v;
    bus.i_Mode       = mode;
    bus.i_Opcode     = op;
    bus.i_AddrReg1   = r1;
    bus.i_AddrReg2   = r2;
    bus.i_Imm        = imm;
    bus.i_InstrReady = rdy;
    clr              = c;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 2'b00, 4'h0, 3'd0, 3'd0, 8'h00, rdy, 1'b0);
  endtask

  // Advance the model with the currently driven inputs, clock once, and
  // compare at the following falling edge.
  task automatic step(input string tag);
    bit rdy_m, vld_m, acc;
    logic [15:0] w;
    rdy_m = q.size() < 4;
    vld_m = q.size() != 0;
    acc   = bus.i_Valid && rdy_m;
    w     = enc(bus.i_Mode, bus.i_Opcode, bus.i_AddrReg1, bus.i_AddrReg2, bus.i_Imm);
    if (vld_m && bus.i_InstrReady) void'(q.pop_front());
    if (acc && !bus.i_Mode[1]) q.push_back(w);
    if (acc && bus.i_Mode[1]) m_ill = 1'b1;
    else if (clr) m_ill = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_check(tag);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'b00, 4'h1, 3'd2, 3'd5, 8'h00, 16'h0550};
    vecs[1] = '{2'b01, 4'h0, 3'd7, 3'd0, 8'hA5, 16'h7D28};
    vecs[2] = '{2'b00, 4'hF, 3'd7, 3'd7, 8'hFF, 16'h3FF0};
    vecs[3] = '{2'b01, 4'hF, 3'd0, 3'd7, 8'hFF, 16'h47F8};
    vecs[4] = '{2'b01, 4'h9, 3'd3, 3'd2, 8'h00, 16'h5800};
    vecs[5] = '{2'b00, 4'h0, 3'd0, 3'd0, 8'hFF, 16'h0000};
    vecs[6] = '{2'b01, 4'h0, 3'd1, 3'd6, 8'h01, 16'h4808};

    // Reset state
    idle(1'b0);
    #12;
    check("rst_valid", 16'(bus.o_InstrValid), 16'h0);
    check("rst_instr", bus.o_Instr, 16'h0000);
    check("rst_count", 16'(count), 16'h0);
    check("rst_illegal", 16'(illegal), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_check("rst_rel");

    // Vector table: single word through an empty FIFO, one-cycle latency
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].imm, 1'b0, 1'b0);
      step("vec_push");
      check("vec_word", bus.o_Instr, vecs[i].exp);
      check("vec_vld", 16'(bus.o_InstrValid), 16'h1);
      idle(1'b1);
      step("vec_pop");
      check("vec_empty", 16'(bus.o_InstrValid), 16'h0);
    end

    // Fill with consumer stalled: 4 accepted, 5th refused, head held
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 4'(i + 2), 3'(i), 3'(7 - i), 8'h00, 1'b0, 1'b0);
      step("fill");
      check("fill_head", bus.o_Instr, 16'h0870);
    end
    check("full_count", 16'(count), 16'h4);
    check("full_ready", 16'(bus.o_Ready), 16'h0);
    // Offer while full with a pop: no bypass, request must be refused
    drive(1'b1, 2'b01, 4'h0, 3'd5, 3'd0, 8'h3C, 1'b1, 1'b0);
    step("full_pop");
    check("full_nopush", 16'(count), 16'h3);
    idle(1'b1);
    for (int i = 0; i < 3; i++) step("drain");
    check("drained", 16'(count), 16'h0);

    // Steady push+pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, 4'h0, 3'(i), 3'd0, 8'(i * 17), 1'b0, 1'b0);
      step("pre2");
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b01, 4'h0, 3'(i + 2), 3'd0, 8'(i * 31 + 5), 1'b1, 1'b0);
      step("stream");
      check("stream_count", 16'(count), 16'h2);
    end
    idle(1'b1);
    step("s_drain");
    step("s_drain");

    // Illegal mode handling
    drive(1'b1, 2'b10, 4'h3, 3'd1, 3'd1, 8'h11, 1'b0, 1'b0);
    check("ill_ready", 16'(bus.o_Ready), 16'h1);
    step("ill");
    check("ill_set", 16'(illegal), 16'h1);
    check("ill_nopush", 16'(count), 16'h0);
    drive(1'b0, 2'b00, 4'h0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1);
    step("ill_clr");
    check("ill_cleared", 16'(illegal), 16'h0);
    drive(1'b1, 2'b11, 4'h0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
    step("ill2");
    drive(1'b1, 2'b10, 4'h0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1);
    step("ill_vs_clr");
    check("ill_set_wins", 16'(illegal), 16'h1);

    // Asynchronous reset mid-stream with 3 words buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 4'hA, 3'(i), 3'd1, 8'h00, 1'b0, 1'b0);
      step("pre_rst");
    end
    check("pre_rst_count", 16'(count), 16'h3);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 16'(bus.o_InstrValid), 16'h0);
    check("arst_count", 16'(count), 16'h0);
    check("arst_illegal", 16'(illegal), 16'h0);
    q.delete();
    m_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b01, 4'h0, 3'd6, 3'd0, 8'h5A, 1'b0, 1'b0);
    step("post_rst");
    check("post_rst_first", bus.o_Instr, 16'h72D0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 7) == 0 ? 2 + $urandom_range(0, 1)
                                                                         : $urandom_range(0, 1)),
            4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
